// File: rtl/rs232_response_transmitter.sv
// Serialises a latched multi-byte response as back-to-back 8N1 UART frames.
// Byte 0 is the top byte of tx_bytes; uart_tx is registered and idles high.
//
// state | meaning
// IDLE  | line high, waiting for a tx_valid rising edge
// START | start bit (low) for one bit period
// DATA  | eight data bits, LSB first
// STOP  | stop bit (high); chains to START while bytes remain
module rs232_response_transmitter #(
    parameter int MAX_BYTES    = 6,
    parameter int CLKS_PER_BIT = 434,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [MAX_BYTES*8-1:0] tx_bytes,
    input  logic [3:0]             tx_num_bytes,
    input  logic                   tx_valid,
    output logic                   uart_tx,
    output logic                   busy,
    output logic                   done,
    output logic                   overrun
);

    localparam int                   W        = MAX_BYTES * 8;
    localparam logic [CNT_WIDTH-1:0] BIT_LOAD = CNT_WIDTH'(CLKS_PER_BIT - 1);
    localparam logic [3:0]           MAX_N    = 4'(MAX_BYTES);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state, state_next;
    logic                 tx_valid_last;
    logic [CNT_WIDTH-1:0] period_cnt, period_next;
    logic [2:0]           bit_cnt, bit_next;
    logic [3:0]           remaining, remaining_next;
    logic [W-1:0]         shadow, shadow_next;
    logic                 busy_next, done_next, overrun_next, uart_tx_next;

    logic                 request;
    logic                 period_tc;
    logic                 accept_slot;
    logic [3:0]           num_clamped;
    logic [7:0]           cur_byte;

    assign request     = tx_valid & ~tx_valid_last;
    assign period_tc   = (period_cnt == '0);
    assign num_clamped = (tx_num_bytes > MAX_N) ? MAX_N : tx_num_bytes;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            tx_valid_last <= 1'b0;
            period_cnt    <= '0;
            bit_cnt       <= '0;
            remaining     <= '0;
            shadow        <= '0;
            uart_tx       <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            state         <= state_next;
            tx_valid_last <= tx_valid;
            period_cnt    <= period_next;
            bit_cnt       <= bit_next;
            remaining     <= remaining_next;
            shadow        <= shadow_next;
            uart_tx       <= uart_tx_next;
            busy          <= busy_next;
            done          <= done_next;
            overrun       <= overrun_next;
        end
    end

    always_comb begin
        state_next     = state;
        period_next    = period_cnt;
        bit_next       = bit_cnt;
        remaining_next = remaining;
        shadow_next    = shadow;
        busy_next      = busy;
        done_next      = 1'b0;
        overrun_next   = 1'b0;
        accept_slot    = 1'b0;

        case (state)
            IDLE: accept_slot = 1'b1;
            START: begin
                if (period_tc) begin
                    state_next  = DATA;
                    period_next = BIT_LOAD;
                    bit_next    = 3'd0;
                end else begin
                    period_next = period_cnt - 1'b1;
                end
            end
            DATA: begin
                if (period_tc) begin
                    period_next = BIT_LOAD;
                    if (bit_cnt == 3'd7) state_next = STOP;
                    else bit_next = bit_cnt + 3'd1;
                end else begin
                    period_next = period_cnt - 1'b1;
                end
            end
            STOP: begin
                if (period_tc) begin
                    if (remaining > 4'd1) begin
                        remaining_next = remaining - 4'd1;
                        shadow_next    = shadow << 8;
                        state_next     = START;
                        period_next    = BIT_LOAD;
                    end else begin
                        state_next  = IDLE;
                        busy_next   = 1'b0;
                        done_next   = 1'b1;
                        accept_slot = 1'b1;
                    end
                end else begin
                    period_next = period_cnt - 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        // A request landing on the completion edge is a fresh start, not an overrun.
        if (request) begin
            if (accept_slot) begin
                if (num_clamped != 4'd0) begin
                    state_next     = START;
                    shadow_next    = tx_bytes;
                    remaining_next = num_clamped;
                    period_next    = BIT_LOAD;
                    bit_next       = 3'd0;
                    busy_next      = 1'b1;
                end else begin
                    done_next = 1'b1;
                end
            end else begin
                overrun_next = 1'b1;
            end
        end
    end

    // Line level is computed from next-state values so uart_tx changes on the accepting edge.
    always_comb begin
        cur_byte = shadow_next[W-1 -: 8];
        case (state_next)
            START:   uart_tx_next = 1'b0;
            DATA:    uart_tx_next = cur_byte[bit_next];
            default: uart_tx_next = 1'b1;
        endcase
    end

endmodule
